fpu_accumulator: RTL



---
 rtl/fpu_accumulator.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fpu_accumulator.sv
// fpu_accumulator
// Sums a stream of len_i float32 operands. The block does no arithmetic of
// its own: each partial sum goes through one exec/done transaction on an
// external adder. The sequencer is IDLE -> WAIT_DATA -> ISSUE -> WAIT_ADD,
// then back to WAIT_DATA or on to DONE, and DONE returns to IDLE.
// At most one adder transaction is outstanding at any time.
module fpu_accumulator #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_ni,
  // Accumulation request
  input  logic               start_i,
  input  logic [COUNT_W-1:0] len_i,
  output logic               busy_o,
  // Operand stream
  input  logic [31:0]        data_i,
  input  logic               data_valid_i,
  output logic               data_ready_o,
  // External adder
  output logic [31:0]        add_a_o,
  output logic [31:0]        add_b_o,
  output logic               add_exec_strobe_o,
  input  logic               add_done_strobe_i,
  input  logic [31:0]        add_z_i,
  // Result
  output logic [31:0]        result_o,
  output logic               result_valid_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ADD  = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Running sum starts at +0.0, so a lone -0.0 term gives +0.0 under IEEE
  // round-to-nearest addition.
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        acc;
  logic [COUNT_W-1:0] remaining;

  // Qualified events. A done strobe counts only in WAIT_ADD, which is what
  // makes a late completion after reset, or a spurious pulse, harmless.
  logic start_fire;
  logic data_fire;
  logic add_fire;
  logic last_term;

  assign start_fire = (state == S_IDLE)      && start_i;
  assign data_fire  = (state == S_WAIT_DATA) && data_valid_i;
  assign add_fire   = (state == S_WAIT_ADD)  && add_done_strobe_i;
  // remaining is at least 1 in WAIT_ADD, so the decrement below cannot wrap.
  assign last_term  = (remaining == COUNT_W'(1));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking (<=) assignments, so
  // every flop samples the values from before the edge; blocking updates
  // here would make the result depend on the order of the statements.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case statement, so every path
  // through this block assigns it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = (len_i == '0) ? S_DONE : S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        // No timeout: the producer may stall for as long as it likes.
        if (data_valid_i) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT_ADD;
      end
      S_WAIT_ADD: begin
        if (add_done_strobe_i) begin
          state_nxt = last_term ? S_DONE : S_WAIT_DATA;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: combinational outputs
  // ---------------------------------------------------------------------
  // Ready and busy depend only on the state, so the producer never sees a
  // combinational path from data_valid_i back to data_ready_o.
  always_comb begin
    busy_o       = (state != S_IDLE);
    data_ready_o = (state == S_WAIT_DATA);
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // Running sum and terms left: loaded on start, updated on each completion.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      acc       <= POS_ZERO;
      remaining <= '0;
    end else if (start_fire) begin
      acc       <= POS_ZERO;
      remaining <= len_i;
    end else if (add_fire) begin
      acc       <= add_z_i;
      remaining <= remaining - COUNT_W'(1);
    end
  end

  // Adder operands: captured at the handshake and held untouched until the
  // next handshake, so they are stable for the whole ISSUE/WAIT_ADD window
  // whatever the adder latency.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      add_a_o <= '0;
      add_b_o <= '0;
    end else if (data_fire) begin
      add_a_o <= acc;
      add_b_o <= data_i;
    end
  end

  // Exec strobe: registered so that it is high for exactly the ISSUE cycle
  // and is glitch-free toward the adder.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      add_exec_strobe_o <= 1'b0;
    end else begin
      add_exec_strobe_o <= data_fire;
    end
  end

  // Result: acc is copied out when DONE is left. result_o and the
  // result_valid_o pulse change on the same edge, and result_o then holds
  // until the next completion.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= (state == S_DONE);
      if (state == S_DONE) begin
        result_o <= acc;
      end
    end
  end

endmodule
